// File: rtl/mmio_output_port.sv
// ---------------------------------------------------------------------------
// mmio_output_port
//   Memory-mapped output port on the data-memory bus. Stores to a four-word
//   register window are decoded here. DATA stores are queued in a FIFO that
//   drains to an external consumer over a valid/ready link. STATUS, ID and
//   HALT can be read back on the registered read-data bus. HALT is a sticky
//   end-of-program flag.
//
//   Register window (offset = Address - BASE_ADDR):
//     0 DATA    W: push word          R: 16'h0000 (never pops)
//     1 STATUS  W: bit2 clears ovf    R: {count[7:0], 5'b0, ovf, empty, full}
//     2 ID      W: ignored            R: 16'h4D10
//     3 HALT    W: set Halted         R: {15'b0, Halted}
//
// Ports
//   Clock      system clock, rising edge
//   Reset      synchronous, active-high; wins over any same-cycle access
//   MemWrite   store strobe, one cycle per store
//   MemRead    load strobe, one cycle per load
//   Address    word address
//   WriteData  store data
//   Hit        combinational window decode of Address
//   ReadData   registered load data, valid the cycle after MemRead && Hit
//   OutData    FIFO head word (zero while empty)
//   OutValid   FIFO non-empty
//   OutReady   consumer takes the head when OutValid && OutReady
//   Halted     sticky flag set by a store to HALT
// ---------------------------------------------------------------------------
module mmio_output_port #(
    parameter logic [15:0] BASE_ADDR = 16'hFFF0,
    parameter int          DEPTH     = 8,
    parameter int          PTR_W     = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [15:0] Address,
    input  logic [15:0] WriteData,
    output logic        Hit,
    output logic [15:0] ReadData,
    output logic [15:0] OutData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        Halted
);

    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [15:0]      ID_VAL   = 16'h4D10;

    // ---------------------------------------------------------------------
    // Address decode. The subtraction wraps, so "offset < 4" is exactly the
    // BASE_ADDR..BASE_ADDR+3 window.
    // ---------------------------------------------------------------------
    logic [15:0] offset;
    logic [1:0]  reg_sel;

    assign offset  = Address - BASE_ADDR;
    assign Hit     = (offset < 16'd4);
    assign reg_sel = offset[1:0];

    logic wr_data, wr_status, wr_halt, rd_hit;

    assign wr_data   = MemWrite && Hit && (reg_sel == 2'd0);
    assign wr_status = MemWrite && Hit && (reg_sel == 2'd1);
    assign wr_halt   = MemWrite && Hit && (reg_sel == 2'd3);
    assign rd_hit    = MemRead  && Hit;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [15:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic             halted_q, halted_d;
    logic [15:0]      rdata_q,  rdata_d;

    logic full, empty, pop, push_ok, drop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A push into a full FIFO still fits when the head leaves in the same
    // cycle; otherwise the word is lost and ovf records it.
    assign pop     = !empty && OutReady;
    assign push_ok = wr_data && (!full || pop);
    assign drop    = wr_data && full && !pop;

    // Count zero-extended to at least 8 bits for the STATUS layout.
    logic [8:0]  cnt_ext;
    logic [15:0] status_word;

    assign cnt_ext     = 9'(count_q);
    assign status_word = {cnt_ext[7:0], 5'b0, ovf_q, empty, full};

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        halted_d = halted_q;
        rdata_d  = rdata_q;

        if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)
            ovf_d = 1'b1;
        else if (wr_status && WriteData[2])
            ovf_d = 1'b0;

        if (wr_halt) halted_d = 1'b1;

        // Reads see pre-edge state, so a same-cycle push/pop is not visible.
        if (rd_hit) begin
            case (reg_sel)
                2'd0:    rdata_d = 16'h0000;
                2'd1:    rdata_d = status_word;
                2'd2:    rdata_d = ID_VAL;
                default: rdata_d = {15'b0, halted_q};
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            halted_q <= 1'b0;
            rdata_q  <= 16'h0000;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            halted_q <= halted_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage array needs no reset: nothing is visible while count is zero.
    always_ff @(posedge Clock) begin
        if (!Reset && push_ok)
            mem_q[wr_ptr_q] <= WriteData;
    end

    // ---------------------------------------------------------------------
    // Outputs come from registered state only.
    // ---------------------------------------------------------------------
    assign OutValid = !empty;
    assign OutData  = empty ? 16'h0000 : mem_q[rd_ptr_q];
    assign ReadData = rdata_q;
    assign Halted   = halted_q;

endmodule
